// File: rtl/sync_fifo_pkg.sv
// Shared types and elaboration helpers for the programmable synchronous FIFO.
// Behaviour of the FIFO itself depends on macro SYNC_FIFO_FWFT_EN (see sync_fifo_prog).
package sync_fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// WIDTH x DEPTH storage, one write and one read port. Registered read by default,
// asynchronous read when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = mem[raddr];

  // Read strobe and reset only matter for the registered-read port.
  logic unused_ctl;
  assign unused_ctl = re ^ reset;
`else
  always_ff @(posedge clk) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for show-ahead reads; default is 1-cycle registered read.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 1024,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       d_in,
  input  logic                   w_enb,
  input  logic                   r_enb,
  input  logic                   err_clr,
  output logic [WIDTH-1:0]       d_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_chk_depth
    $error("sync_fifo_prog: DEPTH must be a power of two");
  end
  if (AF_THRESH > DEPTH) begin : g_chk_af
    $error("sync_fifo_prog: AF_THRESH exceeds DEPTH");
  end
  if (AE_THRESH >= DEPTH) begin : g_chk_ae
    $error("sync_fifo_prog: AE_THRESH must be below DEPTH");
  end

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q, udf_q;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rdata;
  fifo_status_t     status;

  // Acceptance uses only pre-edge flags, so a read on full never frees a slot for a same-cycle write.
  assign wr_acc = w_enb & ~status.full;
  assign rd_acc = r_enb & ~status.empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      ovf_q <= (w_enb & status.full)  | (ovf_q & ~err_clr);
      udf_q <= (r_enb & status.empty) | (udf_q & ~err_clr);
    end
  end

  assign status.full         = (cnt_q == CW'(DEPTH));
  assign status.empty        = (cnt_q == '0);
  assign status.almost_full  = (cnt_q >= CW'(AF_THRESH));
  assign status.almost_empty = (cnt_q <= CW'(AE_THRESH));
  assign status.overflow     = ovf_q;
  assign status.underflow    = udf_q;

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc & reset),
    .waddr (wr_ptr),
    .wdata (d_in),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign d_out = status.empty ? '0 : mem_rdata;
`else
  assign d_out = mem_rdata;
`endif

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;
  assign count        = cnt_q;

endmodule
